ex_cube_cbrt_unit: RTL and testbench

Multi-cycle extension responder. It sits on the CPU's func1 start/busy handshake and computes out = a^3 + 2*floor(cbrt(b)) on unsigned operands. Operands come from rs1/rs2. The CPU stalls its PC while busy_o is high and writes `out` to rd on the first cycle busy_o is low. All arithmetic is sequential: one shared shift-add multiplier plus a bit-serial cube root.

---
 rtl/ex_cube_cbrt_unit_if.sv | 26 ++
 rtl/ex_cube_cbrt_unit.sv | 197 +++++++++++++++++++
 tb/tb_ex_cube_cbrt_unit.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/ex_cube_cbrt_unit_if.sv
// Start/busy handshake bundle between the CPU func1 port and the cube/cube-root responder.
`timescale 1ns/1ps

interface ex_cube_cbrt_unit_if;
  logic        start_i;
  logic [31:0] a_bi;
  logic [31:0] b_bi;
  logic        busy_o;
  logic [31:0] out;

  modport master (
    output start_i,
    output a_bi,
    output b_bi,
    input  busy_o,
    input  out
  );

  modport slave (
    input  start_i,
    input  a_bi,
    input  b_bi,
    output busy_o,
    output out
  );
endinterface

// File: rtl/ex_cube_cbrt_unit.sv
// Sequential responder computing out = a^3 + 2*floor(cbrt(b)) with one shared
// shift-add multiplier; latency is fixed by WIDTH and independent of operands.
`timescale 1ns/1ps

module ex_cube_cbrt_unit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  ex_cube_cbrt_unit_if.slave   bus
);

  localparam int unsigned W  = WIDTH;
  localparam int unsigned K  = (W + 2) / 3;
  localparam int unsigned PW = 3 * W;
  localparam int unsigned CW = $clog2(W + 1);
  localparam int unsigned SW = CW + 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CBRT,
    S_CUBE,
    S_SUM,
    S_DONE
  } state_t;

  // Each root trial and the final cube are two chained products: square, then times operand.
  typedef enum logic {
    PH_SQ,
    PH_CU
  } phase_t;

  state_t          state_q,  state_d;
  phase_t          phase_q,  phase_d;
  logic [W-1:0]    a_q,      a_d;
  logic [W-1:0]    b_q,      b_d;
  logic [K-1:0]    y_q,      y_d;
  logic [CW-1:0]   iter_q,   iter_d;
  logic [PW-1:0]   mcand_q,  mcand_d;
  logic [W-1:0]    mplier_q, mplier_d;
  logic [PW-1:0]   acc_q,    acc_d;
  logic [CW-1:0]   mcnt_q,   mcnt_d;
  logic [31:0]     out_q,    out_d;

  logic [PW-1:0]   prod;
  logic            mul_last;
  logic [K-1:0]    trial;
  logic [K-1:0]    y_next;
  logic [K-1:0]    next_trial;
  logic [W-1:0]    b_win;
  logic            keep;

  // State and datapath registers; reset discards any computation in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      phase_q  <= PH_SQ;
      a_q      <= '0;
      b_q      <= '0;
      y_q      <= '0;
      iter_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      mcnt_q   <= '0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      a_q      <= a_d;
      b_q      <= b_d;
      y_q      <= y_d;
      iter_q   <= iter_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      mcnt_q   <= mcnt_d;
      out_q    <= out_d;
    end
  end

  // Next state and datapath: one multiplier bit per clock in CBRT and CUBE.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    a_d      = a_q;
    b_d      = b_q;
    y_d      = y_q;
    iter_d   = iter_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    mcnt_d   = mcnt_q;
    out_d    = out_q;

    prod       = acc_q + (mplier_q[0] ? mcand_q : '0);
    mul_last   = (mcnt_q == '0);
    trial      = K'({y_q, 1'b1});
    b_win      = b_q >> (SW'(iter_q) * SW'(3));
    keep       = (prod <= PW'(b_win));
    y_next     = keep ? trial : K'({y_q, 1'b0});
    next_trial = K'({y_next, 1'b1});

    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          a_d      = bus.a_bi[W-1:0];
          b_d      = bus.b_bi[W-1:0];
          y_d      = '0;
          iter_d   = CW'(K - 1);
          phase_d  = PH_SQ;
          mcand_d  = PW'(1);
          mplier_d = W'(1);
          acc_d    = '0;
          mcnt_d   = CW'(K - 1);
          state_d  = S_CBRT;
        end
      end

      S_CBRT: begin
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        acc_d    = prod;
        mcnt_d   = mcnt_q - CW'(1);
        if (mul_last) begin
          acc_d = '0;
          if (phase_q == PH_SQ) begin
            mcand_d  = prod;
            mplier_d = W'(trial);
            mcnt_d   = CW'(K - 1);
            phase_d  = PH_CU;
          end else begin
            // Trial cube is compared against b aligned to the current root bit.
            y_d     = y_next;
            phase_d = PH_SQ;
            if (iter_q == '0) begin
              mcand_d  = PW'(a_q);
              mplier_d = a_q;
              mcnt_d   = CW'(W - 1);
              state_d  = S_CUBE;
            end else begin
              iter_d   = iter_q - CW'(1);
              mcand_d  = PW'(next_trial);
              mplier_d = W'(next_trial);
              mcnt_d   = CW'(K - 1);
            end
          end
        end
      end

      S_CUBE: begin
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        acc_d    = prod;
        mcnt_d   = mcnt_q - CW'(1);
        if (mul_last) begin
          if (phase_q == PH_SQ) begin
            acc_d    = '0;
            mcand_d  = prod;
            mplier_d = a_q;
            mcnt_d   = CW'(W - 1);
            phase_d  = PH_CU;
          end else begin
            phase_d = PH_SQ;
            state_d = S_SUM;
          end
        end
      end

      S_SUM: begin
        out_d   = 32'(acc_q) + 32'({y_q, 1'b0});
        state_d = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Stall asserts combinationally in the request cycle so the PC never advances past it.
  assign bus.busy_o = ~rst_i & (((state_q == S_IDLE) & bus.start_i) |
                                (state_q == S_CBRT) |
                                (state_q == S_CUBE) |
                                (state_q == S_SUM));
  assign bus.out    = out_q;

  if (W < 32) begin : g_unused
    logic unused_hi;
    assign unused_hi = ^{bus.a_bi[31:W], bus.b_bi[31:W]};
  end

endmodule

// File: tb/tb_ex_cube_cbrt_unit.sv
// Scoreboard bench for ex_cube_cbrt_unit: requests push expected results, a
// negedge monitor pops and checks them when the unit reaches DONE.
`timescale 1ns/1ps

module tb_ex_cube_cbrt_unit;
  localparam int unsigned W = 8;

  logic clk;
  logic rst;
  ex_cube_cbrt_unit_if bus ();

  ex_cube_cbrt_unit #(.WIDTH(W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          done_count = 0;
  int          busy_run = 0;
  int          ref_n = 0;
  logic [31:0] last_out = '0;
  logic [31:0] exp_q[$];

  // Reference: plain integer cube plus twice the largest y with y^3 <= b.
  function automatic logic [31:0] model(input logic [31:0] ai, input logic [31:0] bi);
    longint unsigned a, b, y;
    a = longint'(ai) & ((64'd1 << W) - 1);
    b = longint'(bi) & ((64'd1 << W) - 1);
    y = 0;
    while ((y + 1) * (y + 1) * (y + 1) <= b) y++;
    return 32'(a * a * a + 2 * y);
  endfunction

  // Monitor: count busy cycles; the first non-busy cycle after a busy run is DONE.
  always @(negedge clk) begin
    if (rst) begin
      busy_run = 0;
      last_out = '0;
    end else if (bus.busy_o) begin
      busy_run++;
    end else if (busy_run > 0) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done: got out=%0d, required no completion", bus.out);
      end else begin
        last_out = exp_q.pop_front();
        if (bus.out !== last_out) begin
          fails++;
          $display("FAIL result: got out=%0d, required %0d", bus.out, last_out);
        end
      end
      tests++;
      if (ref_n == 0) begin
        ref_n = busy_run;
        if (busy_run > 64) begin
          fails++;
          $display("FAIL latency_bound: got N=%0d, required <=64", busy_run);
        end
      end else if (busy_run != ref_n) begin
        fails++;
        $display("FAIL latency_const: got N=%0d, required %0d", busy_run, ref_n);
      end
      busy_run = 0;
      done_count++;
    end else begin
      tests++;
      if (bus.out !== last_out) begin
        fails++;
        $display("FAIL out_hold: got out=%0d, required %0d", bus.out, last_out);
      end
    end
  end

  // Present a request in the next cycle and check the stall is immediate.
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    bus.a_bi    = a;
    bus.b_bi    = b;
    bus.start_i = 1'b1;
    exp_q.push_back(model(a, b));
    @(negedge clk);
    tests++;
    if (bus.busy_o !== 1'b1) begin
      fails++;
      $display("FAIL busy_request: got busy=%0b, required 1", bus.busy_o);
    end
  endtask

  task automatic wait_done();
    int  snap;
    bit  seen;
    snap = done_count;
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (done_count != snap) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL timeout: got no DONE within 200 cycles, required completion");
    end
  endtask

  task automatic release_start();
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b);
    issue(a, b);
    wait_done();
    release_start();
  endtask

  initial begin
    logic [31:0] da [8];
    logic [31:0] db [8];
    da = '{32'd2, 32'd3, 32'd0, 32'hFFFF_FFFF, 32'd7, 32'd1, 32'd255, 32'd10};
    db = '{32'd27, 32'd26, 32'd0, 32'hFFFF_FFFF, 32'd63, 32'd216, 32'd0, 32'd64};

    rst         = 1'b1;
    bus.start_i = 1'b1;
    bus.a_bi    = 32'd9;
    bus.b_bi    = 32'd9;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if (bus.busy_o !== 1'b0 || bus.out !== 32'd0) begin
      fails++;
      $display("FAIL reset_state: got busy=%0b out=%0d, required busy=0 out=0", bus.busy_o, bus.out);
    end
    bus.start_i = 1'b0;
    #1 rst = 1'b0;

    // Directed operands including exact cubes, zeros and set upper bits.
    for (int i = 0; i < 8; i++) run(da[i], db[i]);

    // Back-to-back: start stays high through DONE, then a same-operand repeat.
    issue(32'd1, 32'd8);
    wait_done();
    issue(32'd4, 32'd64);
    wait_done();
    issue(32'd4, 32'd64);
    wait_done();
    release_start();

    // Random operands, scrambled inputs after capture, optional early start drop.
    for (int i = 0; i < 24; i++) begin
      issue($urandom, $urandom);
      repeat ($urandom_range(1, 25)) @(posedge clk);
      #1;
      bus.a_bi = $urandom;
      bus.b_bi = $urandom;
      if ($urandom_range(0, 1) == 1) bus.start_i = 1'b0;
      wait_done();
      release_start();
    end

    // Reset in the middle of the cube product aborts everything.
    issue(32'd7, 32'd100);
    repeat (25) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    tests++;
    if (bus.busy_o !== 1'b0 || bus.out !== 32'd0) begin
      fails++;
      $display("FAIL reset_midop: got busy=%0b out=%0d, required busy=0 out=0", bus.busy_o, bus.out);
    end
    exp_q.delete();
    @(posedge clk);
    #2;
    bus.start_i = 1'b0;
    rst = 1'b0;
    run(32'd5, 32'd125);

    repeat (4) @(posedge clk);
    @(negedge clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL pending: got %0d outstanding results, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
